// File: rtl/single_buffer_reader_pkg.sv
// Shared types and default geometry for the banked single frame buffer
// and its read-side sequencer.
package single_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    localparam int DEF_ADDRESS_DEPTH    = 512;
    localparam int DEF_BANK_COUNT       = 3;
    localparam int DEF_BLOCK_COUNT      = 4;
    localparam int DEF_BLOCK_DATA_WIDTH = 32;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/single_buffer_reader_fifo.sv
// Small synchronous FIFO that catches buffer read data after the RAM
// latency; the head word is held in an output register.
module read_skid_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    rd_ptr_nxt;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop     = pop && (count != '0);
    assign do_push    = push && ((count != CW'(DEPTH)) || do_pop);
    assign rd_ptr_nxt = do_pop ? ptr_inc(rd_ptr) : rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            rd_ptr <= rd_ptr_nxt;
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage and head register; a push landing on the next head slot bypasses the array.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
        if (do_push && (wr_ptr == rd_ptr_nxt)) begin
            rd_data <= wr_data;
        end else begin
            rd_data <= mem[rd_ptr_nxt];
        end
    end

endmodule

// File: rtl/single_buffer_reader.sv
// Read-side sequencer: reads a frame from all banks in parallel and streams
// each flattened word out on a valid/ready interface in address order.
module single_buffer_reader
    import single_buffer_pkg::*;
#(
    parameter int ADDRESS_DEPTH    = DEF_ADDRESS_DEPTH,
    parameter int BANK_COUNT       = DEF_BANK_COUNT,
    parameter int BLOCK_COUNT      = DEF_BLOCK_COUNT,
    parameter int BLOCK_DATA_WIDTH = DEF_BLOCK_DATA_WIDTH,
    parameter int BANDWIDTH        = BLOCK_COUNT * BLOCK_DATA_WIDTH,
    parameter int READ_LATENCY     = 1,
    localparam int AW = addr_w(ADDRESS_DEPTH),
    localparam int DW = BANDWIDTH * BANK_COUNT
) (
    input  logic                     clkb,
    input  logic                     resetb,
    input  logic                     start,
    input  logic [AW:0]              frame_words,
    output logic                     busy,
    output logic                     done,
    output logic                     ceb,
    output logic [AW*BANK_COUNT-1:0] adb,
    input  logic [DW-1:0]            dout_flat,
    output logic [DW-1:0]            m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     m_last
);

    localparam int FD  = READ_LATENCY + 1;
    localparam int FCW = $clog2(FD + 1);
    localparam int CRW = $clog2(READ_LATENCY + 2);
    localparam logic [CRW-1:0] CREDIT_MAX = CRW'(READ_LATENCY + 1);
    localparam logic [AW:0]    DEPTH_W    = (AW + 1)'(ADDRESS_DEPTH);

    state_t                  state;
    logic [AW:0]             total;
    logic [AW:0]             issued;
    logic [AW:0]             delivered;
    logic [AW:0]             words_clamped;
    logic [AW-1:0]           last_adb;
    logic [CRW-1:0]          credits;
    logic [READ_LATENCY-1:0] tag_p;
    logic                    issue;
    logic                    pop;
    logic [DW-1:0]           fifo_data;
    logic [FCW-1:0]          fifo_count;

    assign words_clamped = (frame_words > DEPTH_W) ? DEPTH_W : frame_words;

    // A pop in the same cycle frees a slot, so issuing on it keeps full rate at zero credits.
    assign pop     = m_valid && m_ready;
    assign issue   = (state == READ) && (issued != total) && ((credits != '0) || pop);
    assign ceb     = issue;
    assign adb     = {BANK_COUNT{issue ? issued[AW-1:0] : last_adb}};
    assign m_valid = (fifo_count != '0);
    assign m_data  = m_valid ? fifo_data : '0;
    assign m_last  = m_valid && (delivered == total - 1'b1);

    always_ff @(posedge clkb) begin
        if (resetb) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            total     <= '0;
            issued    <= '0;
            delivered <= '0;
            last_adb  <= '0;
        end else begin
            if (issue) begin
                issued   <= issued + 1'b1;
                last_adb <= issued[AW-1:0];
            end
            if (pop) begin
                delivered <= delivered + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= READ;
                        busy      <= 1'b1;
                        total     <= words_clamped;
                        issued    <= '0;
                        delivered <= '0;
                        last_adb  <= '0;
                    end
                end
                READ: begin
                    // An empty frame passes through READ for one idle cycle before DONE.
                    if (total == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (issue && (issued == total - 1'b1)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && m_last) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clkb) begin
        if (resetb) begin
            credits <= CREDIT_MAX;
        end else if (issue && !pop) begin
            credits <= credits - 1'b1;
        end else if (pop && !issue) begin
            credits <= credits + 1'b1;
        end
    end

    // Read-latency stage: tag marks which buffer output cycles carry requested data.
    if (READ_LATENCY == 1) begin : g_tag_one
        always_ff @(posedge clkb) begin
            if (resetb) begin
                tag_p <= '0;
            end else begin
                tag_p <= issue;
            end
        end
    end else begin : g_tag_multi
        always_ff @(posedge clkb) begin
            if (resetb) begin
                tag_p <= '0;
            end else begin
                tag_p <= {tag_p[READ_LATENCY-2:0], issue};
            end
        end
    end

    // Skid stage: tagged read data lands here and drains to the stream.
    read_skid_fifo #(
        .DEPTH (FD),
        .WIDTH (DW)
    ) u_fifo (
        .clk     (clkb),
        .rst     (resetb),
        .push    (tag_p[READ_LATENCY-1]),
        .wr_data (dout_flat),
        .pop     (pop),
        .rd_data (fifo_data),
        .count   (fifo_count)
    );

endmodule
